// File: rtl/seg_disp_pkg.sv
// Shared definitions for the 7-segment display blocks:
// glyph constants, segment bus bit order and the scan slot state type.
package seg_disp_pkg;

    // Segment bus bit order, active-high: {dp,g,f,e,d,c,b,a}
    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [6:0] GLYPH_OFF = 7'h00;

    localparam logic [6:0] GLYPH_0 = 7'h3f;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5b;
    localparam logic [6:0] GLYPH_3 = 7'h4f;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6d;
    localparam logic [6:0] GLYPH_6 = 7'h7d;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7f;
    localparam logic [6:0] GLYPH_9 = 7'h6f;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h7c;
    localparam logic [6:0] GLYPH_C = 7'h39;
    localparam logic [6:0] GLYPH_D = 7'h5e;
    localparam logic [6:0] GLYPH_E = 7'h79;
    localparam logic [6:0] GLYPH_F = 7'h71;

    // Per-slot phase: selects off (anti-ghosting) or digit lit
    typedef enum logic {
        ST_DEAD = 1'b0,
        ST_ON   = 1'b1
    } slot_state_t;

endpackage

// File: rtl/seg7_encode.sv
// Combinational 4-bit code to 7-segment glyph {g,f,e,d,c,b,a}.
// Ports: i_code (digit code), o_glyph (active-high segments, no dp).
module seg7_encode
    import seg_disp_pkg::*;
#(
    parameter int HEX_EN = 0
) (
    input  logic [3:0] i_code,
    output logic [6:0] o_glyph
);

    localparam bit HEX = (HEX_EN != 0);

    always_comb begin
        o_glyph = GLYPH_OFF;
        unique case (i_code)
            4'h0: o_glyph = GLYPH_0;
            4'h1: o_glyph = GLYPH_1;
            4'h2: o_glyph = GLYPH_2;
            4'h3: o_glyph = GLYPH_3;
            4'h4: o_glyph = GLYPH_4;
            4'h5: o_glyph = GLYPH_5;
            4'h6: o_glyph = GLYPH_6;
            4'h7: o_glyph = GLYPH_7;
            4'h8: o_glyph = GLYPH_8;
            4'h9: o_glyph = GLYPH_9;
            4'hA: o_glyph = HEX ? GLYPH_A : GLYPH_OFF;
            4'hB: o_glyph = HEX ? GLYPH_B : GLYPH_OFF;
            4'hC: o_glyph = HEX ? GLYPH_C : GLYPH_OFF;
            4'hD: o_glyph = HEX ? GLYPH_D : GLYPH_OFF;
            4'hE: o_glyph = HEX ? GLYPH_E : GLYPH_OFF;
            4'hF: o_glyph = HEX ? GLYPH_F : GLYPH_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed N-digit 7-segment scanner with shadow capture,
// per-digit dp/blank/blink, leading-zero suppression and dead time.
// Ports: CLK, RST (async, active-high), load (shadow capture),
//   digits_in/dp_in/blank_in/blink_in (per-digit data),
//   lz_suppress (live), Digitron_Out {dp,g..a} active-high,
//   DigitronCS_Out active-low selects, frame_done (1-cycle pulse).
module seg_scan_display
    import seg_disp_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int SCAN_TICKS   = 50000,
    parameter int DEAD_TICKS   = 500,
    parameter int BLINK_FRAMES = 64,
    parameter int HEX_EN       = 0
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   digits_in,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic [N_DIGITS-1:0]     blank_in,
    input  logic [N_DIGITS-1:0]     blink_in,
    input  logic                    lz_suppress,
    output logic [7:0]              Digitron_Out,
    output logic [N_DIGITS-1:0]     DigitronCS_Out,
    output logic                    frame_done
);

    localparam int CNT_W = $clog2(SCAN_TICKS);
    localparam int IDX_W = $clog2(N_DIGITS);
    localparam int FRM_W =
        (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_TICKS - 1);
    localparam logic [CNT_W-1:0] DEAD_LIM = CNT_W'(DEAD_TICKS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    // With no dead time a slot starts directly lit
    localparam slot_state_t ST_RESET =
        (DEAD_TICKS > 0) ? ST_DEAD : ST_ON;

    // Scan counters
    logic [CNT_W-1:0]          r_cnt;
    logic [IDX_W-1:0]          r_idx;
    logic [FRM_W-1:0]          r_frm;
    logic                      r_blink_on;
    slot_state_t               r_state;

    // Shadow registers
    logic [N_DIGITS-1:0][3:0]  r_digits;
    logic [N_DIGITS-1:0]       r_dp;
    logic [N_DIGITS-1:0]       r_blank;
    logic [N_DIGITS-1:0]       r_blink;

    // Registered pins
    logic [7:0]                r_seg;
    logic [N_DIGITS-1:0]       r_cs;
    logic                      r_frame_done;

    logic                      w_slot_end;
    logic                      w_frame_end;
    logic [CNT_W-1:0]          w_cnt_nxt;
    slot_state_t               w_state_nxt;
    logic [3:0]                w_code;
    logic [6:0]                w_glyph;
    logic [N_DIGITS-1:0]       w_lz;
    logic                      w_dark;
    logic [7:0]                w_seg_lit;
    logic [7:0]                w_seg_nxt;
    logic [N_DIGITS-1:0]       w_cs_nxt;

    always_comb begin
        w_slot_end  = (r_cnt == CNT_LAST);
        w_frame_end = w_slot_end && (r_idx == IDX_LAST);
        w_cnt_nxt   = w_slot_end ? '0 : r_cnt + 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt      <= '0;
            r_idx      <= '0;
            r_frm      <= '0;
            r_blink_on <= 1'b1;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_slot_end) begin
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end
            if (w_frame_end) begin
                if (r_frm == FRM_LAST) begin
                    r_frm      <= '0;
                    r_blink_on <= ~r_blink_on;
                end else begin
                    r_frm <= r_frm + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_digits <= '0;
            r_dp     <= '0;
            r_blank  <= '0;
            r_blink  <= '0;
        end else if (load) begin
            r_digits <= digits_in;
            r_dp     <= dp_in;
            r_blank  <= blank_in;
            r_blink  <= blink_in;
        end
    end

    assign w_code = r_digits[r_idx];

    seg7_encode #(
        .HEX_EN (HEX_EN)
    ) u_enc (
        .i_code  (w_code),
        .o_glyph (w_glyph)
    );

    // A digit is a leading zero when it and all digits above it
    // hold code 0; scan from the top down accumulating that fact.
    always_comb begin
        logic v_zero;
        w_lz   = '0;
        v_zero = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            v_zero  = v_zero & (r_digits[i] == 4'h0);
            w_lz[i] = lz_suppress & v_zero;
        end
    end

    assign w_dark = r_blank[r_idx]
                  | (r_blink[r_idx] & ~r_blink_on);

    always_comb begin
        w_seg_lit = SEG_BLANK;
        if (w_dark) begin
            w_seg_lit = SEG_BLANK;
        end else if (w_lz[r_idx]) begin
            w_seg_lit = {r_dp[r_idx], GLYPH_OFF};
        end else begin
            w_seg_lit = {r_dp[r_idx], w_glyph};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // State tracks the current slot count: DEAD while below the
    // dead-time limit, ON for the rest of the slot.
    always_comb begin
        w_state_nxt = r_state;
        w_cs_nxt    = '1;
        w_seg_nxt   = SEG_BLANK;
        unique case (r_state)
            ST_DEAD: begin
                if (w_cnt_nxt >= DEAD_LIM) begin
                    w_state_nxt = ST_ON;
                end
            end
            ST_ON: begin
                w_cs_nxt[r_idx] = 1'b0;
                w_seg_nxt       = w_seg_lit;
                if (w_cnt_nxt < DEAD_LIM) begin
                    w_state_nxt = ST_DEAD;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_seg        <= SEG_BLANK;
            r_cs         <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_seg        <= w_seg_nxt;
            r_cs         <= w_cs_nxt;
            r_frame_done <= w_frame_end;
        end
    end

    assign Digitron_Out   = r_seg;
    assign DigitronCS_Out = r_cs;
    assign frame_done     = r_frame_done;

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: elapsed-cycle reference model,
// per-cycle compare, literal pins, randomized traffic.
module tb_seg_scan_display;

    localparam int N = 4;
    localparam int S = 8;
    localparam int D = 2;
    localparam int B = 2;

    localparam logic [6:0] GL [16] = '{
        7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
        7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71
    };

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        load = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_in = '0;
    logic [3:0]  blink_in = '0;
    logic        lz_suppress = 1'b0;

    logic [7:0]  seg0, seg1;
    logic [3:0]  cs0, cs1;
    logic        fd0, fd1;

    seg_scan_display #(
        .N_DIGITS(N), .SCAN_TICKS(S), .DEAD_TICKS(D),
        .BLINK_FRAMES(B), .HEX_EN(0)
    ) dut (
        .CLK(CLK), .RST(RST), .load(load),
        .digits_in(digits_in), .dp_in(dp_in),
        .blank_in(blank_in), .blink_in(blink_in),
        .lz_suppress(lz_suppress),
        .Digitron_Out(seg0), .DigitronCS_Out(cs0),
        .frame_done(fd0)
    );

    seg_scan_display #(
        .N_DIGITS(N), .SCAN_TICKS(S), .DEAD_TICKS(D),
        .BLINK_FRAMES(B), .HEX_EN(1)
    ) dut_hex (
        .CLK(CLK), .RST(RST), .load(load),
        .digits_in(digits_in), .dp_in(dp_in),
        .blank_in(blank_in), .blink_in(blink_in),
        .lz_suppress(lz_suppress),
        .Digitron_Out(seg1), .DigitronCS_Out(cs1),
        .frame_done(fd1)
    );

    always #5 CLK = ~CLK;

    int nerr = 0;
    int nchk = 0;

    // Model state: cycles counted since reset release + shadows
    int          m_e;
    logic [15:0] m_dig;
    logic [3:0]  m_dp, m_blank, m_blink;
    logic [3:0]  exp_cs;
    logic [7:0]  exp_seg0, exp_seg1;
    logic        exp_fd;

    logic [7:0]  last0 [4];
    logic [7:0]  last1 [4];
    int          fdcnt;

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at t=%0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] ref_glyph(input logic [3:0] c,
                                             input bit hex);
        if (c > 4'd9 && !hex) return 7'h00;
        return GL[c];
    endfunction

    function automatic logic [7:0] ref_seg(input int idx, input bit hex,
                                           input bit blink_on);
        bit dark, lzs;
        logic [6:0] g;
        dark = m_blank[idx] | (m_blink[idx] & !blink_on);
        lzs  = lz_suppress && idx > 0 && ((m_dig >> (4 * idx)) == 16'h0);
        if (dark) return 8'h00;
        g = lzs ? 7'h00 : ref_glyph(m_dig[4*idx +: 4], hex);
        return {m_dp[idx], g};
    endfunction

    task automatic step();
        int cnt, idx;
        bit bon;
        @(posedge CLK);
        if (RST) begin
            exp_cs = 4'hf; exp_seg0 = 8'h00; exp_seg1 = 8'h00;
            exp_fd = 1'b0;
        end else begin
            cnt = m_e % S;
            idx = (m_e / S) % N;
            bon = (((m_e / (S * N)) / B) % 2) == 0;
            exp_fd = (m_e % (S * N)) == (S * N - 1);
            if (cnt < D) begin
                exp_cs = 4'hf; exp_seg0 = 8'h00; exp_seg1 = 8'h00;
            end else begin
                exp_cs   = ~(4'b0001 << idx);
                exp_seg0 = ref_seg(idx, 1'b0, bon);
                exp_seg1 = ref_seg(idx, 1'b1, bon);
            end
            if (load) begin
                m_dig = digits_in; m_dp = dp_in;
                m_blank = blank_in; m_blink = blink_in;
            end
            m_e++;
        end
        @(negedge CLK);
        check("cs", {4'h0, cs0}, {4'h0, exp_cs});
        check("cs_hex", {4'h0, cs1}, {4'h0, exp_cs});
        check("seg", seg0, exp_seg0);
        check("seg_hex", seg1, exp_seg1);
        check("frame_done", {7'h0, fd0}, {7'h0, exp_fd});
        check("frame_done_hex", {7'h0, fd1}, {7'h0, exp_fd});
        if (fd0) fdcnt++;
        for (int i = 0; i < N; i++) begin
            if (cs0 == ~(4'b0001 << i)) begin
                last0[i] = seg0;
                last1[i] = seg1;
            end
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        #1;
        check("rst_cs", {4'h0, cs0}, 8'h0f);
        check("rst_seg", seg0, 8'h00);
        check("rst_fd", {7'h0, fd0}, 8'h00);
        m_e = 0; m_dig = '0; m_dp = '0; m_blank = '0; m_blink = '0;
        run(2);
        RST = 1'b0;
    endtask

    task automatic load_step(input logic [15:0] d, input logic [3:0] dp,
                             input logic [3:0] bl, input logic [3:0] bk);
        digits_in = d; dp_in = dp; blank_in = bl; blink_in = bk;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    initial begin
        #1;
        do_reset();

        // Plain scan of 4321, frame pulses
        fdcnt = 0;
        load_step(16'h4321, 4'h0, 4'h0, 4'h0);
        run(63);
        check("fd_count", 8'(fdcnt), 8'd2);
        check("lit_d0", last0[0], 8'h06);
        check("lit_d1", last0[1], 8'h5b);
        check("lit_d2", last0[2], 8'h4f);
        check("lit_d3", last0[3], 8'h66);

        // Input change without load is invisible, load shows next cycle
        digits_in = 16'h8888;
        run(40);
        check("noload_d0", last0[0], 8'h06);
        for (int k = 0; k < 40 && (m_e % (S * N)) != 3; k++) step();
        load = 1'b1;
        step();
        load = 1'b0;
        check("load_old", seg0, 8'h06);
        step();
        check("load_new", seg0, 8'h7f);

        // Leading-zero suppression
        lz_suppress = 1'b1;
        load_step(16'h0700, 4'b0100, 4'h0, 4'h0);
        run(40);
        check("lz_d3", last0[3], 8'h00);
        check("lz_d2", last0[2], 8'h87);
        check("lz_d1", last0[1], 8'h3f);
        check("lz_d0", last0[0], 8'h3f);
        load_step(16'h0070, 4'b0100, 4'h0, 4'h0);
        run(40);
        check("lzdp_d3", last0[3], 8'h00);
        check("lzdp_d2", last0[2], 8'h80);
        check("lzdp_d1", last0[1], 8'h07);
        check("lzdp_d0", last0[0], 8'h3f);
        lz_suppress = 1'b0;
        run(40);
        check("nolz_d3", last0[3], 8'h3f);
        check("nolz_d2", last0[2], 8'hbf);

        // Hex glyphs
        load_step(16'hABCD, 4'h0, 4'h0, 4'h0);
        run(40);
        for (int i = 0; i < N; i++) check("nohex", last0[i], 8'h00);
        check("hex_d0", last1[0], 8'h5e);
        check("hex_d1", last1[1], 8'h39);
        check("hex_d2", last1[2], 8'h7c);
        check("hex_d3", last1[3], 8'h77);

        // Blink: two frames on, two frames off
        do_reset();
        last0[0] = 8'hee;
        load_step(16'h0005, 4'h0, 4'h0, 4'b0001);
        run(31);
        check("blink_f0", last0[0], 8'h6d);
        last0[0] = 8'hee;
        run(32);
        check("blink_f1", last0[0], 8'h6d);
        last0[0] = 8'hee;
        run(32);
        check("blink_f2", last0[0], 8'h00);
        check("blink_d1", last0[1], 8'h3f);
        last0[0] = 8'hee;
        run(32);
        check("blink_f3", last0[0], 8'h00);
        last0[0] = 8'hee;
        run(32);
        check("blink_f4", last0[0], 8'h6d);

        // Reset at slot count 5 of digit 2
        do_reset();
        load_step(16'h4321, 4'h0, 4'h0, 4'h0);
        run(20);
        check("pre_rst_cs", {4'h0, cs0}, 8'h0b);
        do_reset();
        step();
        check("rel_cs1", {4'h0, cs0}, 8'h0f);
        step();
        check("rel_cs2", {4'h0, cs0}, 8'h0f);
        step();
        check("rel_cs3", {4'h0, cs0}, 8'h0e);
        check("rel_seg3", seg0, 8'h3f);

        // Randomized traffic with one mid-run reset
        for (int k = 0; k < 600; k++) begin
            if (k == 300) do_reset();
            digits_in   = 16'($urandom);
            dp_in       = 4'($urandom);
            blank_in    = 4'($urandom) & 4'($urandom);
            blink_in    = 4'($urandom);
            lz_suppress = 1'($urandom);
            load        = ($urandom % 8) == 0;
            step();
        end
        load = 1'b0;

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
